mdio_bridge: RTL and testbench
==============================

Name: mdio_bridge

Overview:
- Clause 22 MDIO slave frame decoder, directly upstream of the MDIO register file.
- Samples MDC/MDIO in the clk domain and parses read and write frames addressed to PHYAD.
- Converts each accepted frame into one Wishbone classic single transaction toward the register file.
- Drives MDIO during TA/data of reads; never drives on err, address mismatch or a late ack.

Parameters:
- PHYAD, 5'd0, PHY address this bridge answers to.

Ports:
- clk  input  1  system clock; mdc/mdio_in must already be synchronized to it; clk >= 4x MDC.
- rst  input  1  reset, synchronous, active-high.
- mdc  input  1  synchronized management clock.
- mdio_in  input  1  synchronized MDIO line value.
- mdio_out  output  1  value driven on MDIO when mdio_oe=1.
- mdio_oe  output  1  output enable for the external MDIO tristate.
- cyc  output  1  Wishbone cycle.
- stb  output  1  Wishbone strobe; always equal to cyc.
- we  output  1  Wishbone write enable.
- addr  output  5  register address (REGAD).
- data_write  output  16  write data.
- ack  input  1  Wishbone acknowledge.
- err  input  1  Wishbone error.
- data_read  input  16  read data, valid with ack.

Behaviour:
- Edge detection:
  - mdc_last is registered every clk.
  - An edge cycle is a clk with mdc=1 and mdc_last=0.
  - All frame bits are sampled from mdio_in in edge cycles only.
  - Registered outputs change on the clk after the edge cycle.
- Reset values: cyc=stb=we=0, addr=0, data_write=0, mdio_oe=0, mdio_out=1; state IDLE; preamble count 0; bit count 0.
- IDLE:
  - A sampled 1 increments the 6-bit preamble count, saturating at 32.
  - A sampled 0 with count==32 moves to ST; a 0 with count<32 clears the count.
- ST: 1 -> OP; 0 -> IDLE with count cleared.
- OP (2 bits):
  - 10 = read, 01 = write.
  - 00 or 11 -> IDLE with count cleared.
- PHYAD (5 bits, MSB first):
  - Match -> REGAD.
  - Mismatch -> SKIP; bit count loaded so SKIP consumes REGAD+TA+data = 23 bits, then IDLE.
- REGAD (5 bits, MSB first): shifted into addr.
  - Read: on the clk after the 5th bit, assert cyc/stb with we=0, then go to TA.
  - Write: go to TA.
- Read TA:
  - 1st TA edge:
    - If ack was seen, the read latches data_read into a shift register and sets mdio_oe=1, mdio_out=0.
    - If err was seen, or the cycle is still pending, cyc is dropped (abort), mdio_oe stays 0, and the frame finishes as SKIP.
  - cyc drops on the clk after ack or err; the 1-cycle ack pulse must be captured in a sticky flag.
- Read DATA:
  - After each of the next 16 edges, mdio_out = next bit, MSB first.
  - On the edge sampling the 16th data bit, mdio_oe=0, then IDLE.
- Write TA: 2 bits, ignored.
- Write DATA:
  - 16 bits shifted MSB first into data_write.
  - On the clk after the 16th bit, assert cyc/stb/we=1; hold until ack or err, then drop on the next clk.
  - The FSM returns to IDLE immediately, so a preamble can be counted while the write is pending.
- A read accepted while a write is still pending is treated as a late read: no drive.
- The preamble count is cleared on every exit from IDLE, so each frame needs its own 32-bit preamble.
- rst mid-frame or mid-cycle: all outputs return to reset values on the next clk; any pending Wishbone cycle is dropped.
- Simultaneous ack and err: treated as err.

Optional Feature:
- Macro: MDIO_BROADCAST_EN.
- Defined: PHYAD field 5'd0 also matches. Broadcast writes are performed. Broadcast reads go to SKIP: no cycle, no drive.
- Undefined: only PHYAD matches.

Test Plan:
- PHYAD=5, 32x1 preamble, read of reg 2, ack with data_read=16'h1234 two clks after cyc -> mdio_oe=1 from the 1st TA edge; bits 0 then 0001001000110100; mdio_oe=0 after the last edge.
- Write of reg 0, data 16'h8000 -> exactly one cycle with we=1, addr=0, data_write=16'h8000; cyc held until ack and deasserted the clk after.
- Read of reg 7 answered with err -> cyc drops; mdio_oe stays 0 for the whole frame; next valid frame decodes normally.
- Only 31 preamble ones, or OP=11, or PHYAD=6 -> no cyc, mdio_oe never 1; a 16'hFFFF-looking data field in the skipped frame does not start a new frame.
- Read where ack never arrives -> cyc deasserted at the 1st TA edge; no drive. Pulse rst during read DATA -> mdio_oe=0 and cyc=0 the next clk; state is IDLE.
- With MDIO_BROADCAST_EN, write to PHYAD 0 while PHYAD=5 -> Wishbone write issued. Without it -> no cycle.

Source files
------------

// File: rtl/mdio_bridge.sv
// mdio_bridge: Clause 22 MDIO slave frame decoder that turns each accepted frame into one
// Wishbone classic transaction. Optional MDIO_BROADCAST_EN: PHY address 0 also matches (writes only).
module mdio_bridge #(
    parameter logic [4:0] PHYAD = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [4:0]  addr,
    output logic [15:0] data_write,
    input  logic        ack,
    input  logic        err,
    input  logic [15:0] data_read
);
    typedef enum logic [2:0] {
        StIdle, StSt, StOp, StPhy, StReg, StTa, StData, StSkip
    } state_e;

    state_e      state_q, state_d;
    logic        mdc_last_q;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        op_hi_q, op_hi_d;
    logic        is_read_q, is_read_d;
    logic [4:0]  sh5_q, sh5_d;
    logic [15:0] sh16_q, sh16_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic        oe_q, oe_d;
    logic        out_q, out_d;
    logic        ack_seen_q, ack_seen_d;
    logic        err_seen_q, err_seen_d;

    logic        mdc_edge;
    logic [4:0]  field;
    logic        phy_hit;
    logic        phy_bcast;

    assign mdc_edge = mdc & ~mdc_last_q;
    assign field    = {sh5_q[3:0], mdio_in};
    assign phy_hit  = (field == PHYAD);
`ifdef MDIO_BROADCAST_EN
    assign phy_bcast = (field == 5'd0);
`else
    assign phy_bcast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        mdc_last_q <= mdc;
        if (rst) begin
            state_q    <= StIdle;
            pre_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            op_hi_q    <= 1'b0;
            is_read_q  <= 1'b0;
            sh5_q      <= '0;
            sh16_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= 1'b1;
            ack_seen_q <= 1'b0;
            err_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            op_hi_q    <= op_hi_d;
            is_read_q  <= is_read_d;
            sh5_q      <= sh5_d;
            sh16_q     <= sh16_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            ack_seen_q <= ack_seen_d;
            err_seen_q <= err_seen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        op_hi_d    = op_hi_q;
        is_read_d  = is_read_q;
        sh5_d      = sh5_q;
        sh16_d     = sh16_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        oe_d       = oe_q;
        out_d      = out_q;
        ack_seen_d = ack_seen_q;
        err_seen_d = err_seen_q;

        // Sticky capture of the one-cycle response; err wins over a simultaneous ack.
        if (cyc_q && (ack || err)) begin
            cyc_d      = 1'b0;
            we_d       = 1'b0;
            err_seen_d = err;
            ack_seen_d = ~err;
            if (!err && !we_q) sh16_d = data_read;
        end

        if (mdc_edge) begin
            unique case (state_q)
                StIdle: begin
                    if (mdio_in) begin
                        if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else begin
                        pre_cnt_d = '0;
                        if (pre_cnt_q == 6'd32) state_d = StSt;
                    end
                end
                StSt: begin
                    bit_cnt_d = '0;
                    state_d   = mdio_in ? StOp : StIdle;
                end
                StOp: begin
                    if (bit_cnt_q == 5'd0) begin
                        op_hi_d   = mdio_in;
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = '0;
                        is_read_d = op_hi_q;
                        state_d   = (op_hi_q != mdio_in) ? StPhy : StIdle;
                    end
                end
                StPhy: begin
                    sh5_d = field;
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        // A read arriving while a write is still pending is never answered.
                        if ((phy_hit || (phy_bcast && !is_read_q)) && !(is_read_q && cyc_q)) begin
                            state_d = StReg;
                        end else begin
                            state_d   = StSkip;
                            bit_cnt_d = 5'd22;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                StReg: begin
                    sh5_d = field;
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        state_d   = StTa;
                        if (is_read_q) begin
                            addr_d     = field;
                            cyc_d      = 1'b1;
                            we_d       = 1'b0;
                            ack_seen_d = 1'b0;
                            err_seen_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                StTa: begin
                    if (is_read_q) begin
                        if (ack_seen_q && !err_seen_q && !cyc_q) begin
                            oe_d      = 1'b1;
                            out_d     = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StData;
                        end else begin
                            cyc_d     = 1'b0;
                            we_d      = 1'b0;
                            bit_cnt_d = 5'd16;
                            state_d   = StSkip;
                        end
                    end else if (bit_cnt_q == 5'd1) begin
                        bit_cnt_d = '0;
                        state_d   = StData;
                    end else begin
                        bit_cnt_d = 5'd1;
                    end
                end
                StData: begin
                    if (is_read_q) begin
                        if (bit_cnt_q == 5'd16) begin
                            oe_d    = 1'b0;
                            out_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            out_d     = sh16_q[15];
                            sh16_d    = {sh16_q[14:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        sh16_d = {sh16_q[14:0], mdio_in};
                        if (bit_cnt_q == 5'd15) begin
                            wdata_d    = {sh16_q[14:0], mdio_in};
                            addr_d     = sh5_q;
                            cyc_d      = 1'b1;
                            we_d       = 1'b1;
                            ack_seen_d = 1'b0;
                            err_seen_d = 1'b0;
                            state_d    = StIdle;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                StSkip: begin
                    if (bit_cnt_q == 5'd0) state_d = StIdle;
                    else bit_cnt_d = bit_cnt_q - 5'd1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign mdio_out   = out_q;
    assign mdio_oe    = oe_q;
    assign cyc        = cyc_q;
    assign stb        = cyc_q;
    assign we         = we_q;
    assign addr       = addr_q;
    assign data_write = wdata_q;
endmodule

// File: tb/tb_mdio_bridge.sv
// tb_mdio_bridge: self-checking bench for mdio_bridge with PHYAD=5: a vector table, hand-written
// corner sequences and randomized frames scored by a frame-level reference model.
`timescale 1ns/1ps
module tb_mdio_bridge;
    localparam logic [4:0] Phy = 5'd5;
`ifdef MDIO_BROADCAST_EN
    localparam bit BcastEn = 1'b1;
`else
    localparam bit BcastEn = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, mdc = 1'b0, mdio_in = 1'b1;
    logic mdio_out, mdio_oe, cyc, stb, we;
    logic ack = 1'b0, err = 1'b0;
    logic [4:0]  addr;
    logic [15:0] data_write;
    logic [15:0] data_read = 16'hDEAD;
    int errors = 0, checks = 0;

    mdio_bridge #(.PHYAD(Phy)) dut (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio_in(mdio_in), .mdio_out(mdio_out),
        .mdio_oe(mdio_oe), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
        .data_write(data_write), .ack(ack), .err(err), .data_read(data_read)
    );

    always #5 clk = ~clk;

    // Wishbone responder and bus monitor. mode: 0 ack, 1 err, 2 silent.
    int          resp_mode = 0, resp_delay = 0, wait_cnt = 0, n_cyc = 0;
    logic [15:0] resp_data = '0;
    bit          responded = 0, prev_cyc = 0, oe_seen = 0, stb_bad = 0;
    logic        last_we = 1'b0;
    logic [4:0]  last_addr = '0;
    logic [15:0] last_wdata = '0;

    always @(negedge clk) begin
        ack = 1'b0; err = 1'b0; data_read = 16'hDEAD;
        if (cyc && !prev_cyc) begin
            n_cyc++; last_we = we; last_addr = addr; last_wdata = data_write;
        end
        prev_cyc = cyc;
        if (mdio_oe) oe_seen = 1;
        if (stb !== cyc) stb_bad = 1;
        if (!cyc) begin
            responded = 0; wait_cnt = 0;
        end else if (!responded) begin
            if (wait_cnt >= resp_delay && resp_mode != 2) begin
                if (resp_mode == 0) begin ack = 1'b1; data_read = resp_data; end
                else err = 1'b1;
                responded = 1;
            end
            wait_cnt++;
        end
    end

    logic        fr [0:127];
    int          fr_len = 0, ta_pos = 0;
    logic [17:0] smp_oe, smp_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic b);
        fr[fr_len] = b;
        fr_len++;
    endtask

    task automatic build(input bit sep, input int pre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] d);
        fr_len = 0;
        if (sep) put(1'b0);
        for (int i = 0; i < pre; i++) put(1'b1);
        put(1'b0); put(1'b1); put(op[1]); put(op[0]);
        for (int i = 4; i >= 0; i--) put(phy[i]);
        for (int i = 4; i >= 0; i--) put(rg[i]);
        ta_pos = fr_len;
        put(1'b1); put(op == 2'b01 ? 1'b0 : 1'b1);
        for (int i = 15; i >= 0; i--) put(op == 2'b10 ? 1'b1 : d[i]);
    endtask

    // Each bit: MDC low 3 clks, sample what the slave presents, then MDC high 4 clks.
    task automatic send_bits(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            @(negedge clk); mdio_in = fr[i]; mdc = 1'b0;
            repeat (3) @(negedge clk);
            if (i >= ta_pos && i < ta_pos + 18) begin
                smp_oe[5'(i - ta_pos)]  = mdio_oe;
                smp_out[5'(i - ta_pos)] = mdio_out;
            end
            mdc = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input int n0, input int ncyc, input logic exp_we,
                               input logic [4:0] rg, input logic [15:0] wd, input bit drive,
                               input logic [15:0] rd);
        logic [17:0] eoe, eout;
        eoe = drive ? 18'h3FFFE : 18'h0;
        eout = '0;
        for (int k = 0; k < 16; k++) eout[2 + k] = drive ? rd[15 - k] : 1'b0;
        check({tag, " ncyc"}, 32'(n_cyc - n0), 32'(ncyc));
        if (ncyc == 1) begin
            check({tag, " we"}, 32'(last_we), 32'(exp_we));
            check({tag, " addr"}, 32'(last_addr), 32'(rg));
            if (exp_we) check({tag, " wdata"}, 32'(last_wdata), 32'(wd));
        end
        check({tag, " oe window"}, 32'(smp_oe), 32'(eoe));
        check({tag, " out bits"}, 32'(smp_out & eoe), 32'(eout));
        check({tag, " oe seen"}, 32'(oe_seen), 32'(drive));
        check({tag, " end idle"}, {30'b0, cyc, mdio_oe}, 32'h0);
    endtask

    task automatic run(input string tag, input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] d, input int mode, input int dly,
                       input logic [15:0] rdata, input int ncyc, input bit drive);
        int n0;
        resp_mode = mode; resp_delay = dly; resp_data = rdata;
        build(1, pre, op, phy, rg, d);
        n0 = n_cyc; oe_seen = 0; smp_oe = '0; smp_out = '0;
        send_bits(0, fr_len - 1);
        repeat (4) @(negedge clk);
        check_frame(tag, n0, ncyc, op == 2'b01, rg, d, drive, rdata);
    endtask

    // Reference model: a frame is honoured only with >=32 preamble ones, a legal opcode and an
    // address match; reads are driven only when the register file acks.
    function automatic int model_ncyc(int pre, logic [1:0] op, logic [4:0] phy);
        bit wr    = (op == 2'b01);
        bit legal = (pre >= 32) && (op == 2'b01 || op == 2'b10);
        bit hit   = (phy == Phy) || (BcastEn && wr && phy == 5'd0);
        return (legal && hit) ? 1 : 0;
    endfunction

    typedef struct {
        int pre; logic [1:0] op; logic [4:0] phy; logic [4:0] rg; logic [15:0] d;
        int mode; int dly; logic [15:0] rdata; int ncyc; bit drive;
    } vec_t;
    vec_t tbl [0:9];

    initial begin
        int n0, pres[4], pre, mode, nc;
        logic [1:0] op; logic [4:0] phy; logic [15:0] rd;
        pres = '{31, 32, 33, 36};

        repeat (3) @(negedge clk);
        check("reset cyc/stb/we", {29'b0, cyc, stb, we}, 32'h0);
        check("reset addr", 32'(addr), 32'h0);
        check("reset data_write", 32'(data_write), 32'h0);
        check("reset oe/out", {30'b0, mdio_oe, mdio_out}, 32'h1);
        rst = 1'b0;

        tbl[0] = '{32, 2'b10, 5'd5, 5'd2,  16'h0000, 0, 2, 16'h1234, 1, 1'b1};
        tbl[1] = '{32, 2'b01, 5'd5, 5'd0,  16'h8000, 0, 3, 16'h0000, 1, 1'b0};
        tbl[2] = '{32, 2'b10, 5'd5, 5'd7,  16'h0000, 1, 1, 16'hBEEF, 1, 1'b0};
        tbl[3] = '{32, 2'b10, 5'd5, 5'd3,  16'h0000, 0, 0, 16'hA5C3, 1, 1'b1};
        tbl[4] = '{31, 2'b01, 5'd5, 5'd4,  16'h1111, 0, 0, 16'h0000, 0, 1'b0};
        tbl[5] = '{32, 2'b11, 5'd5, 5'd4,  16'h2222, 0, 0, 16'h0000, 0, 1'b0};
        tbl[6] = '{32, 2'b10, 5'd6, 5'd1,  16'h0000, 0, 1, 16'h5555, 0, 1'b0};
        tbl[7] = '{32, 2'b01, 5'd0, 5'd9,  16'h0F0F, 0, 1, 16'h0000, BcastEn ? 1 : 0, 1'b0};
        tbl[8] = '{40, 2'b01, 5'd5, 5'd31, 16'hFFFF, 0, 2, 16'h0000, 1, 1'b0};
        tbl[9] = '{32, 2'b00, 5'd5, 5'd4,  16'h3333, 0, 0, 16'h0000, 0, 1'b0};
        for (int v = 0; v < 10; v++)
            run($sformatf("vec%0d", v), tbl[v].pre, tbl[v].op, tbl[v].phy, tbl[v].rg, tbl[v].d,
                tbl[v].mode, tbl[v].dly, tbl[v].rdata, tbl[v].ncyc, tbl[v].drive);

        // Read with no response: cycle pending until the first TA edge, then aborted undriven.
        resp_mode = 2; oe_seen = 0;
        build(1, 32, 2'b10, Phy, 5'd1, 16'h0);
        send_bits(0, ta_pos - 1);
        check("noack cyc pending", 32'(cyc), 32'h1);
        send_bits(ta_pos, ta_pos);
        check("noack cyc dropped", {30'b0, cyc, mdio_oe}, 32'h0);
        send_bits(ta_pos + 1, fr_len - 1);
        check("noack no drive", 32'(oe_seen), 32'h0);

        // Skipped frame full of ones must not leak into preamble counting.
        resp_mode = 0; resp_delay = 0; oe_seen = 0; n0 = n_cyc;
        build(1, 32, 2'b01, 5'd6, 5'd1, 16'hFFFF);
        send_bits(0, fr_len - 1);
        build(0, 16, 2'b10, Phy, 5'd2, 16'h0);
        send_bits(0, fr_len - 1);
        repeat (4) @(negedge clk);
        check("skip ffff ncyc", 32'(n_cyc - n0), 32'h0);
        check("skip ffff no drive", 32'(oe_seen), 32'h0);

        // Write left pending: cyc held; a read meanwhile is late and stays undriven.
        resp_mode = 2; n0 = n_cyc;
        build(1, 32, 2'b01, Phy, 5'd12, 16'hC001);
        send_bits(0, fr_len - 1);
        repeat (20) @(negedge clk);
        check("pend write held", {29'b0, cyc, stb, we}, 32'h7);
        check("pend write fields", {11'b0, last_addr, last_wdata}, {11'b0, 5'd12, 16'hC001});
        oe_seen = 0;
        build(1, 32, 2'b10, Phy, 5'd4, 16'h0);
        send_bits(0, fr_len - 1);
        check("late read no cycle", 32'(n_cyc - n0), 32'h1);
        check("late read no drive", 32'(oe_seen), 32'h0);
        resp_mode = 0; resp_delay = 0;
        repeat (3) @(negedge clk);
        check("pend write released", 32'(cyc), 32'h0);

        // Reset during read data phase.
        resp_mode = 0; resp_delay = 1; resp_data = 16'h0000;
        build(1, 32, 2'b10, Phy, 5'd5, 16'h0);
        send_bits(0, ta_pos + 5);
        check("rst pre driving", {30'b0, mdio_oe, mdio_out}, 32'h2);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rst outputs", {28'b0, cyc, mdio_oe, mdio_out, we}, 32'h2);
        rst = 1'b0;
        run("after rst", 32, 2'b01, Phy, 5'd6, 16'h1357, 0, 1, 16'h0, 1, 1'b0);

        for (int r = 0; r < 40; r++) begin
            pre = pres[$urandom_range(0, 3)];
            op  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0, 1:    phy = Phy;
                2:       phy = 5'd6;
                3:       phy = 5'd0;
                default: phy = 5'($urandom);
            endcase
            mode = (op == 2'b10) ? $urandom_range(0, 2) : $urandom_range(0, 1);
            rd = 16'($urandom);
            nc = model_ncyc(pre, op, phy);
            run($sformatf("rand%0d", r), pre, op, phy, 5'($urandom), 16'($urandom), mode,
                $urandom_range(0, 3), rd, nc, nc == 1 && op == 2'b10 && mode == 0);
        end

        check("stb equals cyc", 32'(stb_bad), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
